// File: rtl/param_dm_cache_if.sv
// CPU-side and line-wide memory-side signals of param_dm_cache.
// The slave modport is the cache view; the master modport is the CPU/memory environment view.
interface param_dm_cache_if #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 16
);
  logic                         cpu_req;
  logic                         cpu_we;
  logic [ADDR_W-1:0]            cpu_addr;
  logic [DATA_W-1:0]            cpu_wdata;
  logic [DATA_W-1:0]            cpu_rdata;
  logic                         cpu_ready;
  logic                         cpu_hit;
  logic                         mem_req;
  logic                         mem_we;
  logic [ADDR_W-1:0]            mem_addr;
  logic [LINE_WORDS*DATA_W-1:0] mem_wdata;
  logic [LINE_WORDS*DATA_W-1:0] mem_rdata;
  logic                         mem_ack;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    output cpu_rdata, cpu_ready, cpu_hit, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_ready, cpu_hit, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/param_dm_cache.sv
// Parametrised direct-mapped write-back, write-allocate cache with its own miss FSM.
// Optional hit/miss/writeback counters are enabled by defining CACHE_STATS_EN.
module param_dm_cache #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 16,
  parameter int NUM_LINES  = 64
) (
  input  logic                clk,
  input  logic                rst,
  param_dm_cache_if.slave     bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count,
  output logic [31:0]         wb_count
`endif
);
  localparam int BOFF_W = $clog2(DATA_W / 8);
  localparam int WOFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int OFF_W  = BOFF_W + WOFF_W;
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, REFILL} state_t;

  state_t state, next_state;

  logic                             req_we;
  logic [ADDR_W-1:0]                req_addr;
  logic [DATA_W-1:0]                req_wdata;
  logic                             miss;

  logic [LINE_WORDS-1:0][DATA_W-1:0] data_mem [NUM_LINES];
  logic [TAG_W-1:0]                  tag_mem  [NUM_LINES];
  logic [NUM_LINES-1:0]              valid;
  logic [NUM_LINES-1:0]              dirty;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WOFF_W-1:0] req_woff;
  logic              lookup_hit;
  logic [ADDR_W-1:0] next_mem_addr;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              unused_addr;

  assign req_tag    = req_addr[ADDR_W-1 -: TAG_W];
  assign req_idx    = req_addr[OFF_W +: IDX_W];
  assign req_woff   = req_addr[BOFF_W +: WOFF_W];
  assign lookup_hit = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  // Byte-offset bits never select anything; fold them away explicitly.
  assign unused_addr = ^req_addr;

  // Memory-side outputs are registered from the next state so they are glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state      <= next_state;
      mem_req_q  <= (next_state == WRITEBACK) || (next_state == REFILL);
      mem_we_q   <= (next_state == WRITEBACK);
      mem_addr_q <= next_mem_addr;
    end
  end

  always_comb begin
    next_state    = state;
    next_mem_addr = '0;
    unique case (state)
      IDLE:      if (bus.cpu_req) next_state = COMPARE;
      COMPARE: begin
        if (lookup_hit)                             next_state = IDLE;
        else if (valid[req_idx] && dirty[req_idx])  next_state = WRITEBACK;
        else                                        next_state = REFILL;
      end
      WRITEBACK: if (bus.mem_ack) next_state = REFILL;
      REFILL:    if (bus.mem_ack) next_state = COMPARE;
      default:   next_state = IDLE;
    endcase
    if (next_state == WRITEBACK)
      next_mem_addr = {tag_mem[req_idx], req_idx, {OFF_W{1'b0}}};
    else if (next_state == REFILL)
      next_mem_addr = {req_tag, req_idx, {OFF_W{1'b0}}};
  end

  always_comb begin
    bus.cpu_ready = (state == COMPARE) && lookup_hit;
    bus.cpu_hit   = bus.cpu_ready && !miss;
    bus.cpu_rdata = '0;
    if (bus.cpu_ready)
      bus.cpu_rdata = req_we ? req_wdata : data_mem[req_idx][req_woff];
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = data_mem[req_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      miss      <= 1'b0;
    end else if (state == IDLE && bus.cpu_req) begin
      req_we    <= bus.cpu_we;
      req_addr  <= bus.cpu_addr;
      req_wdata <= bus.cpu_wdata;
      miss      <= 1'b0;
    end else if (state == COMPARE && !lookup_hit) begin
      miss      <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
    end else if (state == COMPARE && lookup_hit && req_we) begin
      dirty[req_idx] <= 1'b1;
    end else if (state == REFILL && bus.mem_ack) begin
      valid[req_idx] <= 1'b1;
      dirty[req_idx] <= 1'b0;
    end
  end

  // Data and tag storage carry no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (state == COMPARE && lookup_hit && req_we) begin
      data_mem[req_idx][req_woff] <= req_wdata;
    end else if (state == REFILL && bus.mem_ack) begin
      data_mem[req_idx] <= bus.mem_rdata;
      tag_mem[req_idx]  <= req_tag;
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (bus.cpu_hit && hit_count != '1)
        hit_count <= hit_count + 32'd1;
      if (state == COMPARE && !lookup_hit && !miss && miss_count != '1)
        miss_count <= miss_count + 32'd1;
      if (state == WRITEBACK && bus.mem_ack && wb_count != '1)
        wb_count <= wb_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_param_dm_cache.sv
// Directed self-checking bench for param_dm_cache with the default parameters.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_param_dm_cache;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [511:0] line_a;
  logic [511:0] line_b;

  always #5 clk = ~clk;

  param_dm_cache_if bus ();

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  logic [31:0] wb_count;
`endif

  param_dm_cache dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus)
`ifdef CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .wb_count   (wb_count)
`endif
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Presents one request for a single capture edge, then withdraws it.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    @(negedge clk);
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
  endtask

  task automatic memAck(input logic [511:0] line);
    bus.mem_rdata = line;
    bus.mem_ack   = 1'b1;
    @(negedge clk);
    bus.mem_ack   = 1'b0;
  endtask

  initial begin
    line_a = '0;
    line_a[31:0]  = 32'hDEAD_BEEF;
    line_a[63:32] = 32'h1111_1111;
    line_b = '0;
    line_b[31:0]  = 32'hCAFE_F00D;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.mem_rdata = '0;
    bus.mem_ack   = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_cpu_ready", bus.cpu_ready, 0);
    checkOutput("rst_cpu_hit",   bus.cpu_hit,   0);
    checkOutput("rst_cpu_rdata", bus.cpu_rdata, 0);
    checkOutput("rst_mem_req",   bus.mem_req,   0);
    checkOutput("rst_mem_we",    bus.mem_we,    0);
    checkOutput("rst_mem_addr",  bus.mem_addr,  0);
    rst = 1'b0;

    // Cold read of 0x40 refills line 1.
    applyStimulus(1'b0, 32'h0000_0040, 32'h0);
    checkOutput("cold_compare_ready", bus.cpu_ready, 0);
    @(negedge clk);
    checkOutput("cold_mem_req",  bus.mem_req,  1);
    checkOutput("cold_mem_we",   bus.mem_we,   0);
    checkOutput("cold_mem_addr", bus.mem_addr, 64'h40);
    checkOutput("cold_wait_ready", bus.cpu_ready, 0);
    memAck(line_a);
    checkOutput("cold_ready", bus.cpu_ready, 1);
    checkOutput("cold_hit",   bus.cpu_hit,   0);
    checkOutput("cold_rdata", bus.cpu_rdata, 64'hDEAD_BEEF);
    checkOutput("cold_req_dropped", bus.mem_req, 0);
    @(negedge clk);

    applyStimulus(1'b0, 32'h0000_0040, 32'h0);
    checkOutput("rehit_ready", bus.cpu_ready, 1);
    checkOutput("rehit_hit",   bus.cpu_hit,   1);
    checkOutput("rehit_rdata", bus.cpu_rdata, 64'hDEAD_BEEF);
    checkOutput("rehit_mem_req", bus.mem_req, 0);
    @(negedge clk);

    applyStimulus(1'b1, 32'h0000_0044, 32'h1234_5678);
    checkOutput("wr_ready", bus.cpu_ready, 1);
    checkOutput("wr_hit",   bus.cpu_hit,   1);
    checkOutput("wr_rdata", bus.cpu_rdata, 64'h1234_5678);
    @(negedge clk);

    applyStimulus(1'b0, 32'h0000_0044, 32'h0);
    checkOutput("rd44_ready", bus.cpu_ready, 1);
    checkOutput("rd44_hit",   bus.cpu_hit,   1);
    checkOutput("rd44_rdata", bus.cpu_rdata, 64'h1234_5678);
    @(negedge clk);

    // Conflict on index 1 with a dirty line: writeback with a slow ack, then refill.
    applyStimulus(1'b0, 32'h0000_1040, 32'h0);
    checkOutput("conf_compare_ready", bus.cpu_ready, 0);
    @(negedge clk);
    checkOutput("wb_mem_req",  bus.mem_req,  1);
    checkOutput("wb_mem_we",   bus.mem_we,   1);
    checkOutput("wb_mem_addr", bus.mem_addr, 64'h40);
    checkOutput("wb_word0", bus.mem_wdata[31:0],  64'hDEAD_BEEF);
    checkOutput("wb_word1", bus.mem_wdata[63:32], 64'h1234_5678);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("wb_hold_req",   bus.mem_req,   1);
      checkOutput("wb_hold_addr",  bus.mem_addr,  64'h40);
      checkOutput("wb_hold_ready", bus.cpu_ready, 0);
    end
    memAck(line_a);
    checkOutput("rf_mem_req",  bus.mem_req,  1);
    checkOutput("rf_mem_we",   bus.mem_we,   0);
    checkOutput("rf_mem_addr", bus.mem_addr, 64'h1040);
    checkOutput("rf_ready",    bus.cpu_ready, 0);
    memAck(line_b);
    checkOutput("conf_ready", bus.cpu_ready, 1);
    checkOutput("conf_hit",   bus.cpu_hit,   0);
    checkOutput("conf_rdata", bus.cpu_rdata, 64'hCAFE_F00D);
    @(negedge clk);
`ifdef CACHE_STATS_EN
    checkOutput("stat_hits",   hit_count,  3);
    checkOutput("stat_misses", miss_count, 2);
    checkOutput("stat_wbs",    wb_count,   1);
`endif

    // Reset while a refill is outstanding.
    applyStimulus(1'b0, 32'h0000_2040, 32'h0);
    @(negedge clk);
    checkOutput("abort_mem_req",  bus.mem_req,  1);
    checkOutput("abort_mem_addr", bus.mem_addr, 64'h2040);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_req_cleared", bus.mem_req,   0);
    checkOutput("abort_ready",       bus.cpu_ready, 0);
`ifdef CACHE_STATS_EN
    checkOutput("stat_rst_hits",   hit_count,  0);
    checkOutput("stat_rst_misses", miss_count, 0);
    checkOutput("stat_rst_wbs",    wb_count,   0);
`endif
    rst = 1'b0;

    applyStimulus(1'b0, 32'h0000_0040, 32'h0);
    checkOutput("post_rst_ready", bus.cpu_ready, 0);
    @(negedge clk);
    checkOutput("post_rst_mem_req",  bus.mem_req,  1);
    checkOutput("post_rst_mem_we",   bus.mem_we,   0);
    checkOutput("post_rst_mem_addr", bus.mem_addr, 64'h40);
    memAck(line_a);
    checkOutput("post_rst_done",  bus.cpu_ready, 1);
    checkOutput("post_rst_hit",   bus.cpu_hit,   0);
    checkOutput("post_rst_rdata", bus.cpu_rdata, 64'hDEAD_BEEF);
    @(negedge clk);
`ifdef CACHE_STATS_EN
    checkOutput("stat_final_misses", miss_count, 1);
    checkOutput("stat_final_hits",   hit_count,  0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
